// File: rtl/led7_scan_decoder.sv
// Recovers an 8-digit numeric display from a multiplexed 7-segment LED bus.
// Each scanned position is debounced, decoded to a 4-bit code and collected
// in a shadow frame; the frame is published once all eight positions are seen.
//
// Handshake: there is no valid/ready pair here. frame_strobe_o is a single-cycle
// qualifier, high on exactly the cycle digits_o/dp_o take a new frame value;
// consumers may sample digits_o/dp_o at any time. frame_valid_o is a level.
module led7_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  led7_an_i,
  input  logic [7:0]  led7_seg_i,
  output logic [31:0] digits_o,
  output logic [7:0]  dp_o,
  output logic        frame_strobe_o,
  output logic        frame_valid_o,
  output logic        an_err_o,
  output logic        seg_err_o,
  output logic [1:0]  fsm_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  localparam logic [3:0]  STABLE_LAST = 4'(STABLE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT);

  state_t      state;
  logic [3:0]  cnt;
  logic [2:0]  pos;
  logic [7:0]  an_q, seg_q, an_p, seg_p;
  logic        samp_vld;
  logic [31:0] shadow;
  logic [7:0]  shadow_dp;
  logic [7:0]  mask;
  logic [15:0] idle_cnt;

  logic [7:0]  inv;
  logic        an_one, an_multi, changed;
  logic [2:0]  an_pos;
  logic        new_run, capture;
  logic [2:0]  cap_pos;
  logic [3:0]  code;
  logic        complete, timeout_hit;

  function automatic logic [3:0] glyph_code(input logic [6:0] g);
    case (g)
      7'b0000001: glyph_code = 4'h0;
      7'b1001111: glyph_code = 4'h1;
      7'b0010010: glyph_code = 4'h2;
      7'b0000110: glyph_code = 4'h3;
      7'b1001100: glyph_code = 4'h4;
      7'b0100100: glyph_code = 4'h5;
      7'b0100000: glyph_code = 4'h6;
      7'b0001111: glyph_code = 4'h7;
      7'b0000000: glyph_code = 4'h8;
      7'b0000100: glyph_code = 4'h9;
      7'b1111111: glyph_code = 4'hB;
      default:    glyph_code = 4'hF;
    endcase
  endfunction

  // Classify the sampled anode and detect any change from the previous sample.
  always_comb begin
    inv      = ~an_q;
    an_one   = 1'b0;
    an_multi = 1'b0;
    an_pos   = 3'd0;
    if (samp_vld) begin
      an_one   = (inv != 8'h00) && ((inv & (inv - 8'd1)) == 8'h00);
      an_multi = (inv != 8'h00) && !an_one;
    end
    for (int k = 0; k < 8; k++) begin
      if (inv[k]) an_pos = 3'(k);
    end
    changed     = {an_q, seg_q} != {an_p, seg_p};
    new_run     = an_one && ((state == IDLE) || changed);
    capture     = (new_run && (STABLE_CYCLES == 1)) ||
                  ((state == SETTLE) && !changed && (cnt + 4'd1 == STABLE_LAST));
    cap_pos     = new_run ? an_pos : pos;
    code        = glyph_code(seg_q[7:1]);
    complete    = (mask == 8'hFF);
    timeout_hit = !capture && (idle_cnt != TIMEOUT_VAL) &&
                  (idle_cnt + 16'd1 == TIMEOUT_VAL);
  end

  // Register the raw bus once, and keep the prior sample for change detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      an_q     <= 8'h00;
      seg_q    <= 8'h00;
      an_p     <= 8'h00;
      seg_p    <= 8'h00;
      samp_vld <= 1'b0;
    end else begin
      an_q     <= led7_an_i;
      seg_q    <= led7_seg_i;
      an_p     <= an_q;
      seg_p    <= seg_q;
      samp_vld <= 1'b1;
    end
  end

  // Debounce FSM: a new single-anode value starts a run, a steady run captures once.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= 4'd0;
      pos   <= 3'd0;
    end else if (new_run) begin
      pos   <= an_pos;
      cnt   <= 4'd0;
      state <= capture ? HELD : SETTLE;
    end else if (capture) begin
      state <= HELD;
    end else if ((state != IDLE) && changed) begin
      state <= IDLE;
    end else if (state == SETTLE) begin
      cnt <= cnt + 4'd1;
    end
  end

  // Shadow frame, seen mask, idle timer, published outputs and sticky errors.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow         <= 32'h0;
      shadow_dp      <= 8'h00;
      mask           <= 8'h00;
      idle_cnt       <= 16'd0;
      digits_o       <= 32'h0;
      dp_o           <= 8'h00;
      frame_strobe_o <= 1'b0;
      frame_valid_o  <= 1'b0;
      an_err_o       <= 1'b0;
      seg_err_o      <= 1'b0;
    end else begin
      frame_strobe_o <= complete;
      if (complete) begin
        digits_o      <= shadow;
        dp_o          <= shadow_dp;
        frame_valid_o <= 1'b1;
      end else if (timeout_hit) begin
        frame_valid_o <= 1'b0;
      end
      // A full mask or a timeout empties the mask; a same-cycle capture still lands.
      mask <= ((complete || timeout_hit) ? 8'h00 : mask) |
              (capture ? (8'h01 << cap_pos) : 8'h00);
      if (capture) begin
        shadow[{cap_pos, 2'b00} +: 4] <= code;
        shadow_dp[cap_pos]            <= ~seg_q[0];
        idle_cnt                      <= 16'd0;
        if (code == 4'hF) seg_err_o <= 1'b1;
      end else if (idle_cnt != TIMEOUT_VAL) begin
        idle_cnt <= idle_cnt + 16'd1;
      end
      if (an_multi) an_err_o <= 1'b1;
    end
  end

  assign fsm_state_o = state;

endmodule

// File: doc/led7_scan_decoder.md
LED7_SCAN_DECODER -- requirements
Module: led7_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical samples required before a digit is captured (legal range 1..15).
REQ-002 SHALL have parameter TIMEOUT, default 65535: number of cycles without a capture after which frame_valid_o drops.
REQ-003 SHALL have port clk_i  in  1: single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i  in  1: reset, synchronous, active-high.
REQ-005 SHALL have port led7_an_i  in  8: scanned anodes, active-low; bit k selects digit position k.
REQ-006 SHALL have port led7_seg_i  in  8: segments, active-low; bits [7:1] = a,b,c,d,e,f,g and bit [0] = dp.
REQ-007 SHALL have port digits_o  out  32: decoded frame; nibble k ([4k+3:4k]) is the code for position k.
REQ-008 SHALL have port dp_o  out  8: decimal point per position, 1 = lit.
REQ-009 SHALL have port frame_strobe_o  out  1: one-cycle pulse on the cycle digits_o/dp_o update.
REQ-010 SHALL have port frame_valid_o  out  1: at least one complete frame has been captured, and no timeout has occurred since.
REQ-011 SHALL have port an_err_o  out  1: sticky flag; a sampled anode pattern had more than one low bit.
REQ-012 SHALL have port seg_err_o  out  1: sticky flag; a captured segment pattern was not a legal glyph.

Function
REQ-013 SHALL register led7_an_i and led7_seg_i once; all decisions use these sampled values.
REQ-014 SHALL classify each sampled anode as BLANK (0xFF), ONE (exactly one bit low) or MULTI (otherwise); MULTI SHALL set an_err_o and behave as BLANK.
REQ-015 SHALL implement FSM IDLE -> SETTLE -> HELD:
  - IDLE: on ONE, load the position, clear the stability counter, go to SETTLE.
  - SETTLE: while {anode, seg} equal the previous sample, increment the counter; on reaching STABLE_CYCLES-1, capture and go to HELD; any change restarts SETTLE with the new value (ONE) or returns to IDLE (BLANK/MULTI).
  - HELD: no further capture; any change in {anode, seg} goes to SETTLE (ONE) or IDLE (BLANK/MULTI).
REQ-016 SHALL decode seg[7:1] on capture as follows; dp = ~seg[0].
  - Glyphs: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, giving codes 0x0 to 0x9.
  - All-off (1111111) SHALL give code 0xB.
  - Any other pattern SHALL give code 0xF and set seg_err_o.
REQ-017 On capture, SHALL write the code and dp into a shadow register at the position and set bit k of an 8-bit seen mask; recapturing a position SHALL overwrite it without error.
REQ-018 On the cycle the seen mask becomes 0xFF:
  - the shadow SHALL copy to digits_o/dp_o on the next edge;
  - frame_strobe_o SHALL be 1 for exactly that cycle;
  - frame_valid_o SHALL set;
  - the mask SHALL clear.
  Capture-to-output latency is 1 cycle; input-to-capture latency is STABLE_CYCLES+1 cycles.
REQ-019 SHALL keep a 16-bit idle counter, cleared on every capture and saturating at TIMEOUT.
  - On reaching TIMEOUT, frame_valid_o SHALL clear and the seen mask SHALL clear; digits_o SHALL hold its value.
  - A timeout coinciding with a frame completion SHALL leave frame_valid_o at 1 (completion wins).
REQ-020 Scan order SHALL NOT matter; positions may arrive in any order and at any dwell time that is at least STABLE_CYCLES.

Reset
REQ-021 When rst_i=1 at a clock edge, the block SHALL set digits_o=0x00000000, dp_o=0x00, frame_strobe_o=0, frame_valid_o=0, an_err_o=0, seg_err_o=0, FSM=IDLE, mask=0, and clear all counters and sample registers.
REQ-022 Reset asserted mid-frame SHALL discard the partial shadow and mask; the first frame after reset SHALL need all 8 positions.
REQ-023 Sticky error flags SHALL clear only on reset.

Verification
REQ-024 Scan positions 0..7 with glyphs 1,2,3,4,5,6,7,8, dwell 8 cycles each, dp off -> digits_o=0x87654321, dp_o=0x00, a single frame_strobe_o pulse, frame_valid_o=1.
REQ-025 Dwell of 3 cycles with STABLE_CYCLES=4 -> no capture, no strobe, digits_o stays 0x00000000.
REQ-026 Drive anode 0xFC for 10 cycles in mid-scan -> an_err_o=1 and remains 1; frame completes once all 8 positions are later seen.
REQ-027 Capture seg 0x00 (all segments and dp lit) at position 3 -> nibble 3 = 0x8 and dp_o[3]=1; seg 0x55 -> nibble = 0xF and seg_err_o=1.
REQ-028 After a full frame, hold anode 0xFF for TIMEOUT cycles (TIMEOUT=100 in the bench) -> frame_valid_o=0 and digits_o unchanged; a new frame sets it back to 1.
REQ-029 Assert rst_i after 5 of 8 positions, then scan all 8 -> outputs are zero after reset, and exactly one strobe occurs on the 8th post-reset capture.
